if_stage: RTL and testbench

Instruction-fetch stage with IF/ID pipeline register for the 5-stage RV32I pipeline. Holds the PC and drives the asynchronous instruction ROM. It registers the fetched word, PC and PC+4 into the IF/ID register that feeds the decode/control stage. It applies redirects (taken branch, JAL, JALR), decode-requested bubbles, and load-use stalls, and inserts canonical NOPs (addi x0,x0,0) as required.

---
 rtl/if_stage.sv | 132 +++++++++++++
 tb/tb_if_stage.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the 5-stage RV32I core.
// Owns the fetch PC and the asynchronous ROM address. Applies redirects,
// post-redirect squash bubbles, decode bubbles and load-use stalls.
module if_stage #(
    parameter int unsigned      XLEN          = 32,
    parameter logic [XLEN-1:0]  RESET_PC      = 32'h0000_0000,
    parameter logic [XLEN-1:0]  NOP_INST      = 32'h0000_0013,
    parameter int unsigned      SQUASH_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic [XLEN-1:0] imem_rdata_i,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            insert_nop_i,
    output logic [XLEN-1:0] pc_id_o,
    output logic [XLEN-1:0] pc4_id_o,
    output logic [XLEN-1:0] inst_id_o,
    output logic            valid_id_o,
    output logic            misalign_o,
    output logic [XLEN-1:0] fetch_count_o
);

    localparam int unsigned     CNT_W     = 2;
    localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);
    localparam logic [CNT_W-1:0] SQ_RELOAD = CNT_W'(SQUASH_CYCLES - 1);
    localparam logic [CNT_W-1:0] SQ_LAST   = CNT_W'(1);
    localparam logic            MULTI_SQ  = (SQUASH_CYCLES > 1);

    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] sq_cnt_q, sq_cnt_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  pc_id_d, pc4_id_d, inst_id_d, fetch_count_d;
    logic             valid_id_d, misalign_d;
    logic             bubble;
    logic [XLEN-1:0]  pc_plus4;

    assign imem_addr_o = pc_q;
    assign pc_plus4    = pc_q + PC_STEP;

    // State, PC and IF/ID registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            sq_cnt_q      <= '0;
            pc_q          <= RESET_PC;
            pc_id_o       <= '0;
            pc4_id_o      <= PC_STEP;
            inst_id_o     <= NOP_INST;
            valid_id_o    <= 1'b0;
            misalign_o    <= 1'b0;
            fetch_count_o <= '0;
        end else begin
            state_q       <= state_d;
            sq_cnt_q      <= sq_cnt_d;
            pc_q          <= pc_d;
            pc_id_o       <= pc_id_d;
            pc4_id_o      <= pc4_id_d;
            inst_id_o     <= inst_id_d;
            valid_id_o    <= valid_id_d;
            misalign_o    <= misalign_d;
            fetch_count_o <= fetch_count_d;
        end
    end

    // Next-state: redirect > squash > insert_nop > stall > normal fetch.
    always_comb begin
        state_d       = state_q;
        sq_cnt_d      = sq_cnt_q;
        pc_d          = pc_q;
        pc_id_d       = pc_id_o;
        pc4_id_d      = pc4_id_o;
        inst_id_d     = inst_id_o;
        valid_id_d    = valid_id_o;
        misalign_d    = misalign_o;
        fetch_count_d = fetch_count_o;
        bubble        = 1'b0;

        if (redirect_i) begin
            // Wrong-path slot is dropped; any pending stall is irrelevant.
            bubble = 1'b1;
            pc_d   = {redirect_pc_i[XLEN-1:2], 2'b00};
            if (MULTI_SQ) begin
                state_d  = SQUASH;
                sq_cnt_d = SQ_RELOAD;
            end else begin
                state_d  = RUN;
                sq_cnt_d = '0;
            end
            if (redirect_pc_i[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
        end else if (state_q == SQUASH) begin
            bubble   = 1'b1;
            sq_cnt_d = sq_cnt_q - CNT_W'(1);
            if (sq_cnt_q == SQ_LAST) begin
                state_d = RUN;
            end
        end else if (insert_nop_i) begin
            bubble = 1'b1;
            if (!stall_i) begin
                pc_d = pc_plus4;
            end
        end else if (stall_i) begin
            // Hold everything; ROM is simply re-read at the same address.
            pc_d = pc_q;
        end else begin
            inst_id_d     = imem_rdata_i;
            pc_id_d       = pc_q;
            pc4_id_d      = pc_plus4;
            valid_id_d    = 1'b1;
            fetch_count_d = fetch_count_o + XLEN'(1);
            pc_d          = pc_plus4;
        end

        // A bubble keeps the PC of the slot it replaces.
        if (bubble) begin
            inst_id_d  = NOP_INST;
            pc_id_d    = pc_q;
            pc4_id_d   = pc_plus4;
            valid_id_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus randomized control
// traffic compared against a slot-level reference model.
module tb_if_stage;

    localparam int unsigned SQ  = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        insert_nop_i;
    logic [31:0] pc_id_o;
    logic [31:0] pc4_id_o;
    logic [31:0] inst_id_o;
    logic        valid_id_o;
    logic        misalign_o;
    logic [31:0] fetch_count_o;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0] m_pc, m_pcid, m_pc4, m_inst, m_cnt;
    logic        m_valid, m_mis;
    int          m_sq;

    logic [161:0] dut_vec, mdl_vec;
    assign dut_vec = {imem_addr_o, pc_id_o, pc4_id_o, inst_id_o, valid_id_o, misalign_o, fetch_count_o};
    assign mdl_vec = {m_pc, m_pcid, m_pc4, m_inst, m_valid, m_mis, m_cnt};

    if_stage #(
        .XLEN(32),
        .RESET_PC(32'h0000_0000),
        .NOP_INST(NOP),
        .SQUASH_CYCLES(SQ)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .imem_addr_o(imem_addr_o),
        .imem_rdata_i(imem_rdata_i),
        .stall_i(stall_i),
        .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .insert_nop_i(insert_nop_i),
        .pc_id_o(pc_id_o),
        .pc4_id_o(pc4_id_o),
        .inst_id_o(inst_id_o),
        .valid_id_o(valid_id_o),
        .misalign_o(misalign_o),
        .fetch_count_o(fetch_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents: two fixed words, hashed pattern elsewhere.
    function automatic logic [31:0] rom(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        if (a == 32'h4) return 32'h00a0_0113;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    assign imem_rdata_i = rom(imem_addr_o);

    task automatic model_reset();
        m_pc = 32'h0; m_pcid = 32'h0; m_pc4 = 32'h4; m_inst = NOP;
        m_valid = 1'b0; m_mis = 1'b0; m_cnt = 32'h0; m_sq = 0;
    endtask

    // One clock edge of the model: decides what kind of slot IF/ID receives.
    task automatic model_edge(input logic s, input logic r, input logic [31:0] rpc, input logic n);
        logic [31:0] cur;
        cur = m_pc;
        if (r) begin
            m_pcid = cur; m_pc4 = cur + 32'd4; m_inst = NOP; m_valid = 1'b0;
            m_pc = rpc & 32'hFFFF_FFFC;
            m_sq = SQ - 1;
            if (rpc % 4 != 0) m_mis = 1'b1;
        end else if (m_sq > 0) begin
            m_pcid = cur; m_pc4 = cur + 32'd4; m_inst = NOP; m_valid = 1'b0;
            m_sq = m_sq - 1;
        end else if (n) begin
            m_pcid = cur; m_pc4 = cur + 32'd4; m_inst = NOP; m_valid = 1'b0;
            if (!s) m_pc = cur + 32'd4;
        end else if (!s) begin
            m_pcid = cur; m_pc4 = cur + 32'd4; m_inst = rom(cur); m_valid = 1'b1;
            m_cnt = m_cnt + 32'd1;
            m_pc = cur + 32'd4;
        end
    endtask

    // Drive one cycle of control inputs, advance DUT and model, settle for sampling.
    task automatic do_edge(input logic s, input logic r, input logic [31:0] rpc, input logic n);
        stall_i = s; redirect_i = r; redirect_pc_i = rpc; insert_nop_i = n;
        @(posedge clk);
        model_edge(s, r, rpc, n);
        #1;
        stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0; insert_nop_i = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (dut_vec !== {32'h0, 32'h0, 32'h4, NOP, 1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset_state got=%h exp=%h", dut_vec, {32'h0, 32'h0, 32'h4, NOP, 1'b0, 1'b0, 32'h0});
        end
    endtask

    task automatic test_seq_fetch();
        do_edge(1'b0, 1'b0, 32'h0, 1'b0);
        checks++;
        if ({inst_id_o, pc_id_o, valid_id_o} !== {32'h0050_0093, 32'h0, 1'b1}) begin
            errors++;
            $display("FAIL seq_edge1 got inst=%h pc=%h v=%b exp inst=00500093 pc=0 v=1", inst_id_o, pc_id_o, valid_id_o);
        end
        do_edge(1'b0, 1'b0, 32'h0, 1'b0);
        checks++;
        if ({inst_id_o, pc_id_o, fetch_count_o} !== {32'h00a0_0113, 32'h4, 32'd2}) begin
            errors++;
            $display("FAIL seq_edge2 got inst=%h pc=%h cnt=%0d exp inst=00a00113 pc=4 cnt=2", inst_id_o, pc_id_o, fetch_count_o);
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 2; i++) begin
            do_edge(1'b1, 1'b0, 32'h0, 1'b0);
            checks++;
            if ({imem_addr_o, inst_id_o, pc_id_o, valid_id_o, fetch_count_o} !== {32'h8, 32'h00a0_0113, 32'h4, 1'b1, 32'd2}) begin
                errors++;
                $display("FAIL stall_hold%0d got addr=%h inst=%h pc=%h v=%b cnt=%0d", i, imem_addr_o, inst_id_o, pc_id_o, valid_id_o, fetch_count_o);
            end
        end
        do_edge(1'b0, 1'b0, 32'h0, 1'b0);
        checks++;
        if ({inst_id_o, pc_id_o, pc4_id_o, imem_addr_o} !== {rom(32'h8), 32'h8, 32'hC, 32'hC}) begin
            errors++;
            $display("FAIL stall_release got inst=%h pc=%h pc4=%h addr=%h exp inst=%h", inst_id_o, pc_id_o, pc4_id_o, imem_addr_o, rom(32'h8));
        end
        do_edge(1'b0, 1'b0, 32'h0, 1'b0);
        checks++;
        if (dut_vec !== mdl_vec) begin
            errors++;
            $display("FAIL stall_after got=%h exp=%h", dut_vec, mdl_vec);
        end
    endtask

    task automatic test_redirect();
        checks++;
        if (imem_addr_o !== 32'h10) begin
            errors++;
            $display("FAIL redirect_pre_pc got=%h exp=00000010", imem_addr_o);
        end
        do_edge(1'b0, 1'b1, 32'h40, 1'b0);
        checks++;
        if ({imem_addr_o, valid_id_o, inst_id_o, pc_id_o} !== {32'h40, 1'b0, NOP, 32'h10}) begin
            errors++;
            $display("FAIL redirect_edge got addr=%h v=%b inst=%h pc=%h", imem_addr_o, valid_id_o, inst_id_o, pc_id_o);
        end
        do_edge(1'b0, 1'b0, 32'h0, 1'b0);
        checks++;
        if ({imem_addr_o, valid_id_o, inst_id_o} !== {32'h40, 1'b0, NOP}) begin
            errors++;
            $display("FAIL redirect_squash got addr=%h v=%b inst=%h", imem_addr_o, valid_id_o, inst_id_o);
        end
        do_edge(1'b0, 1'b0, 32'h0, 1'b0);
        checks++;
        if ({pc_id_o, valid_id_o, inst_id_o} !== {32'h40, 1'b1, rom(32'h40)}) begin
            errors++;
            $display("FAIL redirect_target got pc=%h v=%b inst=%h exp pc=40 v=1", pc_id_o, valid_id_o, inst_id_o);
        end
    endtask

    task automatic test_redirect_stall();
        do_edge(1'b1, 1'b1, 32'h80, 1'b0);
        checks++;
        if ({imem_addr_o, inst_id_o, valid_id_o} !== {32'h80, NOP, 1'b0}) begin
            errors++;
            $display("FAIL redir_stall got addr=%h inst=%h v=%b exp addr=80 inst=13 v=0", imem_addr_o, inst_id_o, valid_id_o);
        end
        // Stall and nop requests inside the squash window must be ignored.
        do_edge(1'b1, 1'b0, 32'h0, 1'b1);
        do_edge(1'b0, 1'b0, 32'h0, 1'b0);
        checks++;
        if (dut_vec !== mdl_vec) begin
            errors++;
            $display("FAIL redir_stall_resume got=%h exp=%h", dut_vec, mdl_vec);
        end
    endtask

    task automatic test_random();
        logic s, r, n;
        logic [31:0] rpc;
        for (int i = 0; i < 400; i++) begin
            r   = ($urandom_range(0, 9) == 0);
            s   = ($urandom_range(0, 3) == 0);
            n   = ($urandom_range(0, 5) == 0);
            rpc = $urandom & 32'h0000_FFFC;
            do_edge(s, r, rpc, n);
            checks++;
            if (dut_vec !== mdl_vec) begin
                errors++;
                $display("FAIL random_cyc%0d s=%b r=%b n=%b got=%h exp=%h", i, s, r, n, dut_vec, mdl_vec);
            end
        end
    endtask

    task automatic test_misalign();
        do_edge(1'b0, 1'b1, 32'h46, 1'b0);
        checks++;
        if ({imem_addr_o, misalign_o} !== {32'h44, 1'b1}) begin
            errors++;
            $display("FAIL misalign_set got addr=%h mis=%b exp addr=44 mis=1", imem_addr_o, misalign_o);
        end
        for (int i = 0; i < 4; i++) begin
            do_edge(1'b0, (i == 2), 32'h100, 1'b0);
        end
        checks++;
        if ({misalign_o, dut_vec} !== {1'b1, mdl_vec}) begin
            errors++;
            $display("FAIL misalign_sticky got mis=%b vec=%h exp=%h", misalign_o, dut_vec, mdl_vec);
        end
    endtask

    task automatic test_wrap();
        do_edge(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        for (int i = 1; i < int'(SQ); i++) do_edge(1'b0, 1'b0, 32'h0, 1'b0);
        do_edge(1'b0, 1'b0, 32'h0, 1'b0);
        checks++;
        if ({imem_addr_o, pc_id_o, pc4_id_o, valid_id_o} !== {32'h0, 32'hFFFF_FFFC, 32'h0, 1'b1}) begin
            errors++;
            $display("FAIL wrap got addr=%h pc=%h pc4=%h v=%b exp addr=0 pc=fffffffc pc4=0 v=1", imem_addr_o, pc_id_o, pc4_id_o, valid_id_o);
        end
        do_edge(1'b0, 1'b0, 32'h0, 1'b0);
        checks++;
        if (dut_vec !== mdl_vec) begin
            errors++;
            $display("FAIL wrap_next got=%h exp=%h", dut_vec, mdl_vec);
        end
    endtask

    task automatic test_async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (dut_vec !== {32'h0, 32'h0, 32'h4, NOP, 1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL async_reset got=%h exp=%h", dut_vec, {32'h0, 32'h0, 32'h4, NOP, 1'b0, 1'b0, 32'h0});
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        do_edge(1'b0, 1'b0, 32'h0, 1'b0);
        checks++;
        if ({inst_id_o, pc_id_o, valid_id_o, fetch_count_o} !== {32'h0050_0093, 32'h0, 1'b1, 32'd1}) begin
            errors++;
            $display("FAIL post_reset_fetch got inst=%h pc=%h v=%b cnt=%0d", inst_id_o, pc_id_o, valid_id_o, fetch_count_o);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0; insert_nop_i = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_seq_fetch();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_random();
        test_misalign();
        test_wrap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog timeout reached errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
